// File: rtl/vectorized_operand_aligner.sv
// Pairs two AXI-Stream operand streams beat-for-beat and feeds them lane-aligned to the vectorized PE array.
// Latency: 1 cycle in the FIFO plus 1 output register (beat pushed on edge k appears after edge k+1).
// Backpressure: sN_tready drops only when FIFO N is full; pops stop when either FIFO is empty or stall is high.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   sN_tdata/tkeep/tlast/tvalid    operand N AXI-Stream input (N = 1, 2)
//   sN_tready                      FIFO N not full
//   stall                          downstream hold, blocks pops
//   o1_PE_typeC, o2_PE_typeC       aligned operand data (registered)
//   o_tvalid1, o_tvalid2           per-lane valid of the aligned beat (0 when no pop)
//   o_last                         aligned beat ends a vector
//   err_last                       sticky, paired beats disagreed on tlast
//   occ1, occ2                     FIFO occupancies

// Small synchronous FIFO, show-ahead head on rd_dat.
// Latency: a write is visible at rd_dat on the cycle after the write edge.
// Backpressure: caller must not write when full nor read when empty; no internal guarding.
module vao_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wptr] <= wr_dat;
    end
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_vld) wptr <= wptr + 1'b1;
      if (rd_vld) rptr <= rptr + 1'b1;
      case ({wr_vld, rd_vld})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rd_dat = mem[rptr];
endmodule

module vectorized_operand_aligner #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SIMD_degree  = 4,
  parameter int dwidth_float = 32,
  parameter int phit_size    = SIMD_degree * dwidth_float
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [phit_size-1:0]          s1_tdata,
  input  logic [SIMD_degree-1:0]        s1_tkeep,
  input  logic                          s1_tlast,
  input  logic                          s1_tvalid,
  output logic                          s1_tready,
  input  logic [phit_size-1:0]          s2_tdata,
  input  logic [SIMD_degree-1:0]        s2_tkeep,
  input  logic                          s2_tlast,
  input  logic                          s2_tvalid,
  output logic                          s2_tready,
  input  logic                          stall,
  output logic [phit_size-1:0]          o1_PE_typeC,
  output logic [phit_size-1:0]          o2_PE_typeC,
  output logic [SIMD_degree-1:0]        o_tvalid1,
  output logic [SIMD_degree-1:0]        o_tvalid2,
  output logic                          o_last,
  output logic                          err_last,
  output logic [$clog2(FIFO_DEPTH):0]   occ1,
  output logic [$clog2(FIFO_DEPTH):0]   occ2
);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [phit_size-1:0]   data;
    logic [SIMD_degree-1:0] keep;
    logic                   last;
  } beat_t;

  beat_t in1;
  beat_t in2;
  beat_t hd1;
  beat_t hd2;
  logic  push1;
  logic  push2;
  logic  pop;

  assign in1 = '{data: s1_tdata, keep: s1_tkeep, last: s1_tlast};
  assign in2 = '{data: s2_tdata, keep: s2_tkeep, last: s2_tlast};

  // Ready looks only at occupancy: a same-cycle pop does not open a slot,
  // which keeps tready free of any path through stall or the partner FIFO.
  assign s1_tready = (occ1 != OW'(FIFO_DEPTH));
  assign s2_tready = (occ2 != OW'(FIFO_DEPTH));

  assign push1 = s1_tvalid & s1_tready;
  assign push2 = s2_tvalid & s2_tready;

  // Both FIFOs pop in lockstep so lane i of operand 1 always meets lane i of operand 2.
  assign pop = (occ1 != '0) & (occ2 != '0) & ~stall;

  vao_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push1),
    .wr_dat (in1),
    .rd_vld (pop),
    .rd_dat (hd1),
    .occ    (occ1)
  );

  vao_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push2),
    .wr_dat (in2),
    .rd_vld (pop),
    .rd_dat (hd2),
    .occ    (occ2)
  );

  // Data words hold between pops; valids and o_last are single-cycle strobes.
  // Invalid lanes are forwarded unmasked, only their valid bit is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      o1_PE_typeC <= '0;
      o2_PE_typeC <= '0;
      o_tvalid1   <= '0;
      o_tvalid2   <= '0;
      o_last      <= 1'b0;
      err_last    <= 1'b0;
    end else begin
      if (pop) begin
        o1_PE_typeC <= hd1.data;
        o2_PE_typeC <= hd2.data;
        o_tvalid1   <= hd1.keep;
        o_tvalid2   <= hd2.keep;
        o_last      <= hd1.last | hd2.last;
        if (hd1.last != hd2.last) begin
          err_last <= 1'b1;
        end
      end else begin
        o_tvalid1 <= '0;
        o_tvalid2 <= '0;
        o_last    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vectorized_operand_aligner.sv
module tb_vectorized_operand_aligner;
  localparam int DEPTH = 4;
  localparam int SIMD  = 4;
  localparam int DW    = 32;
  localparam int PHIT  = SIMD * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [PHIT-1:0]  s1_tdata;
  logic [SIMD-1:0]  s1_tkeep;
  logic             s1_tlast;
  logic             s1_tvalid;
  logic             s1_tready;
  logic [PHIT-1:0]  s2_tdata;
  logic [SIMD-1:0]  s2_tkeep;
  logic             s2_tlast;
  logic             s2_tvalid;
  logic             s2_tready;
  logic             stall;
  logic [PHIT-1:0]  o1_PE_typeC;
  logic [PHIT-1:0]  o2_PE_typeC;
  logic [SIMD-1:0]  o_tvalid1;
  logic [SIMD-1:0]  o_tvalid2;
  logic             o_last;
  logic             err_last;
  logic [2:0]       occ1;
  logic [2:0]       occ2;

  int n_chk  = 0;
  int n_fail = 0;

  // Stream generator state: beat j of stream N carries mk(N, base + j).
  int       sent1, sent2, lim1, lim2, base;
  bit       en1, en2;
  logic [SIMD-1:0] keep1, keep2;
  logic     last1, last2;
  logic [PHIT-1:0] exp1, exp2;

  always #5 clk = ~clk;

  vectorized_operand_aligner #(
    .FIFO_DEPTH   (DEPTH),
    .SIMD_degree  (SIMD),
    .dwidth_float (DW),
    .phit_size    (PHIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s1_tdata    (s1_tdata),
    .s1_tkeep    (s1_tkeep),
    .s1_tlast    (s1_tlast),
    .s1_tvalid   (s1_tvalid),
    .s1_tready   (s1_tready),
    .s2_tdata    (s2_tdata),
    .s2_tkeep    (s2_tkeep),
    .s2_tlast    (s2_tlast),
    .s2_tvalid   (s2_tvalid),
    .s2_tready   (s2_tready),
    .stall       (stall),
    .o1_PE_typeC (o1_PE_typeC),
    .o2_PE_typeC (o2_PE_typeC),
    .o_tvalid1   (o_tvalid1),
    .o_tvalid2   (o_tvalid2),
    .o_last      (o_last),
    .err_last    (err_last),
    .occ1        (occ1),
    .occ2        (occ2)
  );

  function automatic logic [PHIT-1:0] mk(input int tag, input int j);
    logic [31:0] t;
    logic [31:0] v;
    t = tag;
    v = j;
    return {t, v, t, v};
  endfunction

  task automatic chk(input string tag, input logic [PHIT-1:0] obs, input logic [PHIT-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s1_tvalid = en1 && (sent1 < lim1);
    s1_tdata  = mk(1, base + sent1);
    s1_tkeep  = keep1;
    s1_tlast  = last1;
    s2_tvalid = en2 && (sent2 < lim2);
    s2_tdata  = mk(2, base + sent2);
    s2_tkeep  = keep2;
    s2_tlast  = last2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: note handshakes before the edge, advance the generators after it.
  task automatic step();
    logic a1;
    logic a2;
    a1 = s1_tvalid & s1_tready;
    a2 = s2_tvalid & s2_tready;
    tick();
    if (a1) sent1++;
    if (a2) sent2++;
    drive();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    en1 = 1'b0; en2 = 1'b0; sent1 = 0; sent2 = 0; lim1 = 0; lim2 = 0; base = 0;
    keep1 = '1; keep2 = '1; last1 = 1'b0; last2 = 1'b0;
    drive();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_o1",     o1_PE_typeC, '0);
    chk("rst_o2",     o2_PE_typeC, '0);
    chk("rst_tv1",    PHIT'(o_tvalid1), '0);
    chk("rst_tv2",    PHIT'(o_tvalid2), '0);
    chk("rst_olast",  PHIT'(o_last), '0);
    chk("rst_err",    PHIT'(err_last), '0);
    chk("rst_rdy1",   PHIT'(s1_tready), PHIT'(1));
    chk("rst_rdy2",   PHIT'(s2_tready), PHIT'(1));
    chk("rst_occ1",   PHIT'(occ1), '0);
    chk("rst_occ2",   PHIT'(occ2), '0);

    // Single float pair, partial keep on operand 2
    exp1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    exp2 = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
    s1_tdata = exp1; s1_tkeep = 4'b1111; s1_tlast = 1'b1; s1_tvalid = 1'b1;
    s2_tdata = exp2; s2_tkeep = 4'b1011; s2_tlast = 1'b1; s2_tvalid = 1'b1;
    tick();
    s1_tvalid = 1'b0; s2_tvalid = 1'b0;
    chk("single_occ1", PHIT'(occ1), PHIT'(1));
    chk("single_pre_tv1", PHIT'(o_tvalid1), '0);
    tick();
    chk("single_o1",    o1_PE_typeC, exp1);
    chk("single_o2",    o2_PE_typeC, exp2);
    chk("single_tv1",   PHIT'(o_tvalid1), PHIT'(4'b1111));
    chk("single_tv2",   PHIT'(o_tvalid2), PHIT'(4'b1011));
    chk("single_last",  PHIT'(o_last), PHIT'(1));
    chk("single_err",   PHIT'(err_last), '0);
    tick();
    chk("single_tv1_off",  PHIT'(o_tvalid1), '0);
    chk("single_last_off", PHIT'(o_last), '0);
    chk("single_o1_hold",  o1_PE_typeC, exp1);

    // Skewed arrival: s1 fills while s2 is silent
    keep1 = '1; keep2 = '1; last1 = 1'b0; last2 = 1'b0;
    sent1 = 0; sent2 = 0; base = 0; lim1 = 6; lim2 = 6; en1 = 1'b1; en2 = 1'b0;
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("skew_fill_occ1", PHIT'(occ1), PHIT'(i + 1));
    end
    chk("skew_full_rdy1", PHIT'(s1_tready), '0);
    step(); step();
    chk("skew_hold_occ1", PHIT'(occ1), PHIT'(4));
    chk("skew_hold_occ2", PHIT'(occ2), '0);
    chk("skew_hold_tv1",  PHIT'(o_tvalid1), '0);
    chk("skew_hold_rdy1", PHIT'(s1_tready), '0);
    en2 = 1'b1;
    drive();
    step();
    chk("skew_s2_occ2", PHIT'(occ2), PHIT'(1));
    chk("skew_s2_rdy1", PHIT'(s1_tready), '0);
    chk("skew_s2_tv1",  PHIT'(o_tvalid1), '0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("skew_pair_tv1", PHIT'(o_tvalid1), PHIT'(4'hF));
      chk("skew_pair_o1",  o1_PE_typeC, mk(1, i));
      chk("skew_pair_o2",  o2_PE_typeC, mk(2, i));
      if (i == 0) chk("skew_rdy1_back", PHIT'(s1_tready), PHIT'(1));
    end
    step();
    chk("skew_done_tv1",  PHIT'(o_tvalid1), '0);
    chk("skew_done_occ1", PHIT'(occ1), '0);
    chk("skew_done_occ2", PHIT'(occ2), '0);

    // Stall for 3 cycles in continuous traffic
    sent1 = 0; sent2 = 0; base = 16; lim1 = 8; lim2 = 8; en1 = 1'b1; en2 = 1'b1;
    drive();
    step();
    step();
    chk("stall_p0_o1", o1_PE_typeC, mk(1, 16));
    chk("stall_p0_o2", o2_PE_typeC, mk(2, 16));
    step();
    chk("stall_p1_o1", o1_PE_typeC, mk(1, 17));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_tv1", PHIT'(o_tvalid1), '0);
      chk("stall_tv2", PHIT'(o_tvalid2), '0);
    end
    chk("stall_occ1", PHIT'(occ1), PHIT'(4));
    chk("stall_rdy2", PHIT'(s2_tready), '0);
    stall = 1'b0;
    for (int i = 2; i < 8; i++) begin
      step();
      chk("stall_pair_tv1", PHIT'(o_tvalid1), PHIT'(4'hF));
      chk("stall_pair_o1",  o1_PE_typeC, mk(1, 16 + i));
      chk("stall_pair_o2",  o2_PE_typeC, mk(2, 16 + i));
    end
    step();
    chk("stall_done_tv1",  PHIT'(o_tvalid1), '0);
    chk("stall_done_occ1", PHIT'(occ1), '0);

    // tlast mismatch sets sticky error, data still forwarded
    sent1 = 0; sent2 = 0; base = 32; lim1 = 1; lim2 = 1; last1 = 1'b1; last2 = 1'b0;
    drive();
    step();
    chk("mis_err_before", PHIT'(err_last), '0);
    step();
    chk("mis_olast", PHIT'(o_last), PHIT'(1));
    chk("mis_err",   PHIT'(err_last), PHIT'(1));
    chk("mis_o2",    o2_PE_typeC, mk(2, 32));
    step();
    chk("mis_err_sticky", PHIT'(err_last), PHIT'(1));
    chk("mis_olast_off",  PHIT'(o_last), '0);
    last1 = 1'b0; sent1 = 0; sent2 = 0; base = 40;
    drive();
    step(); step();
    chk("mis_match_olast", PHIT'(o_last), '0);
    chk("mis_match_tv1",   PHIT'(o_tvalid1), PHIT'(4'hF));
    chk("mis_match_err",   PHIT'(err_last), PHIT'(1));

    // Reset mid-stream with beats buffered
    stall = 1'b1; sent1 = 0; sent2 = 0; base = 48; lim1 = 3; lim2 = 1;
    drive();
    step(); step(); step();
    chk("mid_occ1", PHIT'(occ1), PHIT'(3));
    chk("mid_occ2", PHIT'(occ2), PHIT'(1));
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0;
    drive();
    step();
    rst = 1'b0;
    chk("mid_rst_occ1",  PHIT'(occ1), '0);
    chk("mid_rst_occ2",  PHIT'(occ2), '0);
    chk("mid_rst_tv1",   PHIT'(o_tvalid1), '0);
    chk("mid_rst_tv2",   PHIT'(o_tvalid2), '0);
    chk("mid_rst_err",   PHIT'(err_last), '0);
    chk("mid_rst_o1",    o1_PE_typeC, '0);
    chk("mid_rst_rdy1",  PHIT'(s1_tready), PHIT'(1));
    stall = 1'b0; sent1 = 0; sent2 = 0; base = 64; lim1 = 2; lim2 = 2; en1 = 1'b1; en2 = 1'b1;
    drive();
    step(); step();
    chk("post_p0_o1",  o1_PE_typeC, mk(1, 64));
    chk("post_p0_o2",  o2_PE_typeC, mk(2, 64));
    chk("post_p0_tv1", PHIT'(o_tvalid1), PHIT'(4'hF));
    step();
    chk("post_p1_o1",  o1_PE_typeC, mk(1, 65));
    chk("post_p1_o2",  o2_PE_typeC, mk(2, 65));
    step();
    chk("post_done_tv1",  PHIT'(o_tvalid1), '0);
    chk("post_done_occ1", PHIT'(occ1), '0);
    chk("post_done_occ2", PHIT'(occ2), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vectorized_operand_aligner.md
Name: vectorized_operand_aligner

Overview:
- Upstream feeder for the vectorized PE array. Accepts two independent AXI-Stream operand streams, each phit_size wide (SIMD_degree lanes of dwidth_float).
- Buffers each stream in a small FIFO and pops one beat from both streams together, so lane i of operand 1 always meets lane i of operand 2.
- Drives i1/i2 data and the per-lane tvalid vectors that the vectorized PE consumes.
- Provides a stall input, per-stream backpressure and a sticky tlast-mismatch flag.

Parameters:
- FIFO_DEPTH, 4, entries per operand FIFO; power of two, at least 2.
- SIMD_degree, phit_size, dwidth_float: shared globals from my_interface.vh; phit_size = SIMD_degree*dwidth_float.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s1_tdata  in  phit_size  operand-1 beat
- s1_tkeep  in  SIMD_degree  operand-1 lane-valid mask
- s1_tlast  in  1  operand-1 end of vector
- s1_tvalid  in  1  operand-1 beat valid
- s1_tready  out  1  operand-1 FIFO can accept
- s2_tdata, s2_tkeep, s2_tlast, s2_tvalid, s2_tready: same as s1, for operand 2
- stall  in  1  downstream hold; inhibits pops
- o1_PE_typeC  out  phit_size  aligned operand-1 to PE
- o2_PE_typeC  out  phit_size  aligned operand-2 to PE
- o_tvalid1  out  SIMD_degree  per-lane valid, operand 1
- o_tvalid2  out  SIMD_degree  per-lane valid, operand 2
- o_last  out  1  aligned beat is end of vector
- err_last  out  1  sticky: paired beats disagreed on tlast
- occ1, occ2  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst sampled on posedge clk only.
  - Clears pointers, occ1/occ2, o1/o2 data, o_tvalid1/2, o_last and err_last to 0.
  - Reset mid-operation discards all buffered beats; the first post-reset cycle behaves as from empty.
- Each FIFO stores {tdata, tkeep, tlast}.
- sN_tready = (occN != FIFO_DEPTH). It is combinational from occupancy and does not depend on sN_tvalid.
- Push N = sN_tvalid & sN_tready, on the clock edge.
  - When full, tready is low even if a pop happens that cycle. No pass-through on full.
- pop = (occ1 != 0) & (occ2 != 0) & !stall. Both FIFOs always pop together; a lone stream never drains.
- Occupancy per FIFO:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - pointers wrap modulo FIFO_DEPTH
- Output register, updated every edge:
  - On pop: o1/o2 take the head tdata; o_tvalid1/o_tvalid2 take the head tkeep; o_last = head1.tlast | head2.tlast.
  - No pop: o_tvalid1/2 = 0 and o_last = 0; o1/o2 hold their last value.
- Latency: a beat accepted on edge k into empty FIFOs (partner already present) drives outputs after edge k+1. That is 1 cycle of FIFO plus 1 output register. Full throughput: 1 aligned beat per cycle when both streams stream continuously and stall=0.
- err_last is set on any pop where head1.tlast != head2.tlast. It clears only on rst. Data is still forwarded.
- tkeep lanes: no data masking is applied. Invalid lanes pass their data unchanged, but their valid bit is 0.
- Stall: while asserted there are no pops and the outputs show valid=0. The FIFOs keep accepting beats until full.
- Empty on one side: the other FIFO fills to FIFO_DEPTH, then its tready drops.

Test Plan:
1. Reset then idle. Required: all outputs 0, s1_tready = s2_tready = 1, occ = 0.
2. Single pair, SIMD_degree=4, dwidth=32.
   - Stimulus: s1 lanes {1.0,2.0,3.0,4.0}, keep 4'b1111, tlast=1; s2 lanes {5.0,6.0,7.0,8.0} same cycle, keep 4'b1011.
   - Required: two edges later, o1/o2 show those words, o_tvalid1 = 4'b1111, o_tvalid2 = 4'b1011, o_last = 1, for exactly 1 cycle.
3. Skewed arrival.
   - Stimulus: 6 beats on s1 with s2 silent.
   - Required: occ1 reaches 4 and s1_tready drops after the 4th beat.
   - Then start s2: pairs emerge in order (s1 beat0 with s2 beat0, and so on) at 1 per cycle, and s1_tready returns the cycle after the first pop.
4. Stall.
   - Stimulus: continuous traffic, stall high for 3 cycles.
   - Required: o_tvalid = 0 for 3 cycles, no beat lost or duplicated, output sequence matches input order.
5. tlast mismatch.
   - Stimulus: pair s1 tlast=1 with s2 tlast=0.
   - Required: o_last = 1, err_last rises on the next edge and stays 1 until rst.
6. Reset mid-stream.
   - Stimulus: occ1 = 3, occ2 = 1, assert rst for 1 cycle.
   - Required: occ = 0, o_tvalid = 0, err_last = 0, and no stale beat emerges after new traffic resumes.
